// File: rtl/fir_pkg.sv
// Shared sizing and state encoding for the FIR sample sequencer.
package fir_pkg;

   localparam int DATA_W = 16;
   localparam int TAPS   = 64;
   localparam int ADDR_W = 6;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_WRITE = 2'd2,
      ST_READ  = 2'd3
   } fir_state_t;

endpackage

// File: rtl/fir_sample_seq.sv
// FIR input sequencer: pops FIFO samples into a circular IMEM delay line
// and streams x[n-k], k=0..TAPS-1, newest first, to the FIR ALU.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | zero-fill IMEM, one address per cycle, 0..TAPS-1
// ST_IDLE  | wait for a sample in the FIFO
// ST_WRITE | pop FIFO, write sample at wptr, capture k=0 word in bypass
// ST_READ  | read (base-k) for k=1..TAPS-1, then next sample or idle
module fir_sample_seq #(
   parameter int DATA_W = fir_pkg::DATA_W,
   parameter int TAPS   = fir_pkg::TAPS,
   parameter int ADDR_W = fir_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_out,
   output logic              fifo_rd,
   output logic              imem_cen,
   output logic              imem_wen,
   output logic [ADDR_W-1:0] imem_a,
   output logic [DATA_W-1:0] imem_d,
   input  logic [DATA_W-1:0] imem_q,
   output logic              samp_valid,
   output logic [DATA_W-1:0] samp_data,
   output logic [ADDR_W-1:0] tap_idx,
   output logic              frame_last
);

   import fir_pkg::*;

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TAPS - 1);

   fir_state_t        state;
   fir_state_t        state_nxt;
   logic [ADDR_W-1:0] clr_cnt;
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] k;
   logic [DATA_W-1:0] bypass;

   // State register plus the address counters and the k=0 bypass word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
         wptr    <= '0;
         base    <= '0;
         k       <= '0;
         bypass  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_CLEAR: clr_cnt <= clr_cnt + ADDR_W'(1);
            ST_WRITE: begin
               bypass <= fifo_out;
               base   <= wptr;
               wptr   <= wptr + ADDR_W'(1);
               k      <= ADDR_W'(1);
            end
            ST_READ:  k <= k + ADDR_W'(1);
            default:  ;
         endcase
      end
   end

   // Next state and IMEM/FIFO strobes; everything is held idle while rst is high.
   always_comb begin
      state_nxt = state;
      fifo_rd   = 1'b0;
      imem_cen  = 1'b1;
      imem_wen  = 1'b1;
      imem_a    = '0;
      imem_d    = '0;
      case (state)
         ST_CLEAR: begin
            imem_cen = 1'b0;
            imem_wen = 1'b0;
            imem_a   = clr_cnt;
            if (clr_cnt == ADDR_LAST) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (!fifo_empty) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            fifo_rd   = 1'b1;
            imem_cen  = 1'b0;
            imem_wen  = 1'b0;
            imem_a    = wptr;
            imem_d    = fifo_out;
            state_nxt = ST_READ;
         end
         ST_READ: begin
            imem_cen = 1'b0;
            imem_a   = base - k;
            if (k == ADDR_LAST) state_nxt = fifo_empty ? ST_IDLE : ST_WRITE;
         end
         default: state_nxt = ST_CLEAR;
      endcase
      if (rst) begin
         fifo_rd  = 1'b0;
         imem_cen = 1'b1;
         imem_wen = 1'b1;
         imem_a   = '0;
         imem_d   = '0;
      end
   end

   // Output stage: valid/tap/last trail the WRITE/READ cycle by one clock,
   // lining up with the IMEM read latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         samp_valid <= 1'b0;
         tap_idx    <= '0;
         frame_last <= 1'b0;
      end else begin
         samp_valid <= (state == ST_WRITE) || (state == ST_READ);
         tap_idx    <= (state == ST_READ) ? k : '0;
         frame_last <= (state == ST_READ) && (k == ADDR_LAST);
      end
   end

   // k=0 comes from the bypass register since IMEM is busy writing it that cycle.
   assign samp_data = !samp_valid     ? '0     :
                      (tap_idx == '0) ? bypass : imem_q;

endmodule

// File: tb/tb_fir_sample_seq.sv
// Directed bench for fir_sample_seq with a FWFT FIFO model and a
// synchronous 64x16 IMEM model (1-cycle read latency).
module tb_fir_sample_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fifo_empty;
   logic [15:0] fifo_out;
   logic        fifo_rd;
   logic        imem_cen;
   logic        imem_wen;
   logic [5:0]  imem_a;
   logic [15:0] imem_d;
   logic [15:0] imem_q = 16'h0;
   logic        samp_valid;
   logic [15:0] samp_data;
   logic [5:0]  tap_idx;
   logic        frame_last;

   int checks = 0;
   int errors = 0;

   fir_sample_seq #(.DATA_W(16), .TAPS(64), .ADDR_W(6)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_out(fifo_out),
      .fifo_rd(fifo_rd), .imem_cen(imem_cen), .imem_wen(imem_wen),
      .imem_a(imem_a), .imem_d(imem_d), .imem_q(imem_q),
      .samp_valid(samp_valid), .samp_data(samp_data), .tap_idx(tap_idx),
      .frame_last(frame_last)
   );

   always #5 clk = ~clk;

   // FIFO model
   logic [15:0] fq [0:1023];
   int rp = 0, wp = 0, pops = 0, bad_pops = 0;
   assign fifo_empty = (rp == wp);
   assign fifo_out   = fq[rp % 1024];
   always @(posedge clk) begin
      if (fifo_rd) begin
         if (rp == wp) bad_pops <= bad_pops + 1;
         else begin
            rp   <= rp + 1;
            pops <= pops + 1;
         end
      end
   end

   // IMEM model; unwritten words read as 16'hDEAD
   logic [15:0] mem [0:63];
   bit          mem_wr [0:63];
   always @(posedge clk) begin
      if (!imem_cen) begin
         if (!imem_wen) begin
            mem[imem_a]    <= imem_d;
            mem_wr[imem_a] <= 1'b1;
         end else begin
            imem_q <= mem_wr[imem_a] ? mem[imem_a] : 16'hDEAD;
         end
      end
   end

   logic [15:0] cap_d  [0:63];
   logic [5:0]  cap_t  [0:63];
   logic [5:0]  cap_ra [0:63];
   int cap_vbad, cap_lbad;

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] v);
      fq[wp % 1024] = v;
      wp = wp + 1;
   endtask

   task automatic wait_rd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (fifo_rd === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   // Collects the 64 output words following a WRITE cycle (no checking).
   task automatic capture_frame();
      cap_vbad = 0;
      cap_lbad = 0;
      for (int j = 0; j < 64; j++) begin
         step();
         cap_d[j]  = samp_data;
         cap_t[j]  = tap_idx;
         cap_ra[j] = imem_a;
         if (samp_valid !== 1'b1) cap_vbad++;
         if (frame_last !== (j == 63)) cap_lbad++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      repeat (64) step();
   endtask

   task automatic test_reset();
      int nz;
      rst = 1'b1;
      step();
      step();
      checks++;
      if ({fifo_rd, imem_cen, imem_wen, imem_a, imem_d, samp_valid, samp_data, tap_idx, frame_last} !==
          {1'b0, 1'b1, 1'b1, 6'd0, 16'd0, 1'b0, 16'd0, 6'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: got rd=%b cen=%b wen=%b a=%0d d=%h v=%b q=%h tap=%0d last=%b, want 0 1 1 0 0 0 0 0 0",
                  fifo_rd, imem_cen, imem_wen, imem_a, imem_d, samp_valid, samp_data, tap_idx, frame_last);
      end
      rst = 1'b0;
      #1;
      for (int i = 0; i < 64; i++) begin
         checks++;
         if ({imem_cen, imem_wen, imem_a, imem_d, fifo_rd, samp_valid} !== {1'b0, 1'b0, 6'(i), 16'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clear_cycle%0d: got cen=%b wen=%b a=%0d d=%h rd=%b v=%b, want 0 0 %0d 0000 0 0",
                     i, imem_cen, imem_wen, imem_a, imem_d, fifo_rd, samp_valid, i);
         end
         step();
      end
      checks++;
      if ({imem_cen, fifo_rd} !== 2'b10) begin
         errors++;
         $display("FAIL idle_after_clear: got cen=%b rd=%b, want cen=1 rd=0", imem_cen, fifo_rd);
      end
      nz = 0;
      for (int i = 0; i < 64; i++) if (!mem_wr[i] || mem[i] !== 16'h0) nz++;
      checks++;
      if (nz != 0) begin
         errors++;
         $display("FAIL clear_mem: %0d words not zero, want 0", nz);
      end
   endtask

   task automatic test_single();
      bit ok;
      int p0, bad;
      p0 = pops;
      push(16'h1234);
      wait_rd(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_wait: no fifo_rd within bound"); end
      checks++;
      if ({imem_a, imem_d, imem_wen, imem_cen} !== {6'd0, 16'h1234, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL single_write: got a=%0d d=%h wen=%b cen=%b, want a=0 d=1234 wen=0 cen=0", imem_a, imem_d, imem_wen, imem_cen);
      end
      capture_frame();
      bad = 0;
      for (int k = 0; k < 64; k++) if (cap_d[k] !== ((k == 0) ? 16'h1234 : 16'h0)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL single_data: k0=%h k1=%h bad=%0d, want k0=1234 rest 0", cap_d[0], cap_d[1], bad); end
      bad = 0;
      for (int k = 0; k < 64; k++) if (cap_t[k] !== 6'(k)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL single_taps: %0d wrong tap_idx values, want 0", bad); end
      checks++;
      if (cap_vbad != 0) begin errors++; $display("FAIL single_valid: %0d gaps, want 0", cap_vbad); end
      checks++;
      if (cap_lbad != 0) begin errors++; $display("FAIL single_last: %0d wrong frame_last, want 0", cap_lbad); end
      step();
      checks++;
      if ({samp_valid, imem_cen} !== 2'b01) begin
         errors++;
         $display("FAIL single_idle: got v=%b cen=%b, want v=0 cen=1", samp_valid, imem_cen);
      end
      checks++;
      if (pops - p0 != 1) begin errors++; $display("FAIL single_pops: got %0d, want 1", pops - p0); end
   endtask

   task automatic test_three();
      bit ok;
      int bad;
      logic [15:0] exp;
      push(16'd1);
      push(16'd2);
      push(16'd3);
      for (int f = 0; f < 3; f++) begin
         wait_rd(ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL three_wait%0d: no fifo_rd", f); end
         checks++;
         if ({imem_a, imem_d} !== {6'(f + 1), 16'(f + 1)}) begin
            errors++;
            $display("FAIL three_write%0d: got a=%0d d=%0d, want a=%0d d=%0d", f, imem_a, imem_d, f + 1, f + 1);
         end
         capture_frame();
         checks++;
         if (cap_vbad != 0) begin errors++; $display("FAIL three_valid%0d: %0d gaps, want 0", f, cap_vbad); end
      end
      bad = 0;
      for (int k = 0; k < 64; k++) begin
         case (k)
            0: exp = 16'd3;
            1: exp = 16'd2;
            2: exp = 16'd1;
            3: exp = 16'h1234;
            default: exp = 16'h0;
         endcase
         if (cap_d[k] !== exp) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL three_data: k0..3=%h %h %h %h bad=%0d, want 3 2 1 1234", cap_d[0], cap_d[1], cap_d[2], cap_d[3], bad);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      int tbad, abad, dbad, vbad, bad;
      logic [5:0] r64;
      do_reset();
      for (int v = 1; v <= 66; v++) push(16'(v));
      tbad = 0; abad = 0; dbad = 0; vbad = 0; r64 = 6'd0;
      for (int f = 0; f < 66; f++) begin
         wait_rd(ok);
         if (!ok) tbad++;
         if (imem_a !== 6'(f % 64)) abad++;
         if (imem_d !== 16'(f + 1)) dbad++;
         capture_frame();
         vbad += cap_vbad;
         if (f == 64) r64 = cap_ra[0];
      end
      checks++;
      if (tbad != 0) begin errors++; $display("FAIL wrap_wait: %0d timeouts, want 0", tbad); end
      checks++;
      if (abad != 0 || dbad != 0) begin errors++; $display("FAIL wrap_writes: %0d bad addr %0d bad data, want 0 0", abad, dbad); end
      checks++;
      if (vbad != 0) begin errors++; $display("FAIL wrap_valid: %0d gaps, want 0", vbad); end
      checks++;
      if (r64 !== 6'd63) begin errors++; $display("FAIL wrap_read_below0: got a=%0d, want 63", r64); end
      bad = 0;
      for (int j = 0; j < 63; j++) if (cap_ra[j] !== 6'(0 - j)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wrap_read_addr: first three %0d %0d %0d bad=%0d, want 0 63 62", cap_ra[0], cap_ra[1], cap_ra[2], bad);
      end
      bad = 0;
      for (int k = 0; k < 64; k++) if (cap_d[k] !== 16'(66 - k)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wrap_data: k0=%0d k1=%0d k63=%0d bad=%0d, want 66 65 3", cap_d[0], cap_d[1], cap_d[63], bad);
      end
   endtask

   task automatic test_late_push();
      bit ok;
      int bad;
      push(16'h0AAA);
      wait_rd(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL late_wait: no fifo_rd"); end
      bad = 0;
      for (int c = 1; c < 64; c++) begin
         step();
         if (c == 10) push(16'h0BBB);
         if (fifo_rd !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL late_early_pop: %0d pops during READ, want 0", bad); end
      step();
      checks++;
      if (fifo_rd !== 1'b1) begin errors++; $display("FAIL late_next_write: got rd=%b, want 1", fifo_rd); end
      capture_frame();
      checks++;
      if ({cap_d[0], cap_d[1], cap_d[2]} !== {16'h0BBB, 16'h0AAA, 16'd66}) begin
         errors++;
         $display("FAIL late_data: got %h %h %h, want 0bbb 0aaa 0042", cap_d[0], cap_d[1], cap_d[2]);
      end
      step();
      checks++;
      if (samp_valid !== 1'b0) begin errors++; $display("FAIL late_idle: got v=%b, want 0", samp_valid); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int p0, rd_bad, v_bad, t_bad;
      p0 = pops;
      for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i));
      wait_rd(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_wait: no fifo_rd"); end
      rd_bad = 0; v_bad = 0; t_bad = 0;
      for (int c = 1; c <= 7 * 64; c++) begin
         step();
         if (fifo_rd !== (c % 64 == 0)) rd_bad++;
         if (samp_valid !== 1'b1) v_bad++;
         if (tap_idx !== 6'((c - 1) % 64)) t_bad++;
      end
      checks++;
      if (rd_bad != 0) begin errors++; $display("FAIL b2b_rd_period: %0d wrong fifo_rd cycles, want 0", rd_bad); end
      checks++;
      if (v_bad != 0) begin errors++; $display("FAIL b2b_valid: %0d gaps, want 0", v_bad); end
      checks++;
      if (t_bad != 0) begin errors++; $display("FAIL b2b_taps: %0d wrong tap_idx, want 0", t_bad); end
      capture_frame();
      checks++;
      if ({cap_d[0], cap_d[1], cap_d[7], cap_d[8]} !== {16'h0107, 16'h0106, 16'h0100, 16'h0BBB}) begin
         errors++;
         $display("FAIL b2b_data: got %h %h %h %h, want 0107 0106 0100 0bbb", cap_d[0], cap_d[1], cap_d[7], cap_d[8]);
      end
      checks++;
      if (pops - p0 != 8) begin errors++; $display("FAIL b2b_pops: got %0d, want 8", pops - p0); end
   endtask

   task automatic test_reset_mid();
      bit ok, found;
      int p0, bad;
      push(16'h0CCC);
      push(16'h0DDD);
      wait_rd(ok);
      found = 1'b0;
      for (int n = 0; n < 100; n++) begin
         step();
         if (samp_valid === 1'b1 && tap_idx === 6'd20) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!(ok && found)) begin errors++; $display("FAIL mid_reach_tap20: got ok=%b found=%b, want 1 1", ok, found); end
      rst = 1'b1;
      p0 = pops;
      step();
      checks++;
      if ({samp_valid, fifo_rd, imem_cen} !== 3'b001) begin
         errors++;
         $display("FAIL mid_reset_outputs: got v=%b rd=%b cen=%b, want 0 0 1", samp_valid, fifo_rd, imem_cen);
      end
      rst = 1'b0;
      #1;
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         if ({imem_cen, imem_wen, imem_a, imem_d, fifo_rd} !== {1'b0, 1'b0, 6'(i), 16'd0, 1'b0}) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL mid_clear: %0d bad CLEAR cycles, want 0", bad); end
      checks++;
      if (pops != p0) begin errors++; $display("FAIL mid_no_pop: got %0d pops, want 0", pops - p0); end
      wait_rd(ok);
      checks++;
      if (!ok || {imem_a, imem_d} !== {6'd0, 16'h0DDD}) begin
         errors++;
         $display("FAIL mid_next_write: got ok=%b a=%0d d=%h, want 1 0 0ddd", ok, imem_a, imem_d);
      end
      capture_frame();
      bad = 0;
      for (int k = 1; k < 64; k++) if (cap_d[k] !== 16'h0) bad++;
      checks++;
      if (cap_d[0] !== 16'h0DDD || bad != 0) begin
         errors++;
         $display("FAIL mid_data: got k0=%h nonzero_hist=%0d, want 0ddd 0", cap_d[0], bad);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_three();
      test_wrap();
      test_late_push();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (bad_pops != 0) begin errors++; $display("FAIL empty_pop: got %0d, want 0", bad_pops); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
